// File: rtl/sipo_framed.sv
// sipo_framed: serial-in/parallel-out deserialiser with framing.
// Collects one serial bit per qualified clock into a WIDTH-bit word. The bit
// order is set by MSB_FIRST. A completed word is copied into a holding
// register and announced with a one-cycle out_valid pulse.
// Optional feature macro: SIPO_FRAMED_PARITY_EN. When it is defined, a
// trailing even-parity bit follows the data bits, and its check result is
// reported on parity_err.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   serial_in    serial data bit, sampled when shift_en=1
//   shift_en     qualifies serial_in on this edge
//   clear        synchronous frame abort (wins over shift_en)
//   parallel_out last completed word, held until the next completion
//   out_valid    one-cycle pulse when parallel_out is updated
//   busy         partial frame buffered (bit_count != 0)
//   bit_count    bits accepted in the current frame
//   parity_err   parity result of the last frame (0 without parity)
module sipo_framed #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             clear,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic             parity_err
);

`ifdef SIPO_FRAMED_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_count;
  logic             r_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_data_bit;
  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] w_word;

  assign w_accept = shift_en & ~clear;
  assign w_last   = w_accept && (r_count == CW'(FL - 1));

  always_comb begin
    w_sr_shift = r_sr;
    if (MSB_FIRST) begin
      w_sr_shift = {r_sr[WIDTH-2:0], serial_in};
    end else begin
      w_sr_shift = {serial_in, r_sr[WIDTH-1:1]};
    end
  end

`ifdef SIPO_FRAMED_PARITY_EN
  logic r_perr;

  // The final bit of a frame is the parity bit. It is not shifted into sr,
  // so the data word is already complete in sr when that bit arrives.
  assign w_data_bit = (r_count != CW'(WIDTH));
  assign w_word     = r_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else if (w_last) begin
      r_perr <= (^r_sr) ^ serial_in;
    end
  end

  assign parity_err = r_perr;
`else
  // The completing bit is a data bit, so the word includes it.
  assign w_data_bit = 1'b1;
  assign w_word     = w_sr_shift;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr    <= '0;
      r_word  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (clear) begin
        r_sr    <= '0;
        r_count <= '0;
      end else if (shift_en) begin
        if (w_data_bit) begin
          r_sr <= w_sr_shift;
        end
        if (w_last) begin
          r_word  <= w_word;
          r_valid <= 1'b1;
          r_count <= '0;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

  assign parallel_out = r_word;
  assign out_valid    = r_valid;
  assign bit_count    = r_count;
  assign busy         = (r_count != '0);

endmodule

// File: tb/tb_sipo_framed.sv
module tb_sipo_framed;

`ifdef SIPO_FRAMED_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b0;
  logic shift_en = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] a_out, b_out;
  logic [7:0] c_out;
  logic       a_v, b_v, c_v, a_b, b_b, c_b, a_p, b_p, c_p;
  logic [2:0] a_c, b_c;
  logic [3:0] c_c;

  sipo_framed #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en),
    .clear(clear), .parallel_out(a_out), .out_valid(a_v), .busy(a_b),
    .bit_count(a_c), .parity_err(a_p));

  sipo_framed #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en),
    .clear(clear), .parallel_out(b_out), .out_valid(b_v), .busy(b_b),
    .bit_count(b_c), .parity_err(b_p));

  sipo_framed #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en),
    .clear(clear), .parallel_out(c_out), .out_valid(c_v), .busy(c_b),
    .bit_count(c_c), .parity_err(c_p));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
  endtask

  // Reference model: bits of the current frame are kept in arrival order.
  int          mw[3]   = '{4, 4, 8};
  bit          mmsb[3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mbits[3];
  int          mcnt[3];
  logic [31:0] mout[3];
  logic        mval[3];
  logic        mperr[3];

  function automatic int fl(input int k);
    return mw[k] + (PAR ? 1 : 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mbits[k] = '0; mcnt[k] = 0; mout[k] = '0; mval[k] = 1'b0; mperr[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic si, input logic en, input logic clr);
    for (int k = 0; k < 3; k++) begin
      mval[k] = 1'b0;
      if (clr) begin
        mcnt[k] = 0;
      end else if (en) begin
        mbits[k][mcnt[k]] = si;
        mcnt[k]++;
        if (mcnt[k] == fl(k)) begin
          logic [31:0] w;
          int ones;
          w = '0;
          ones = 0;
          for (int i = 0; i < mw[k]; i++) begin
            if (mmsb[k]) w[mw[k]-1-i] = mbits[k][i];
            else         w[i]         = mbits[k][i];
          end
          for (int i = 0; i < fl(k); i++) ones += int'(mbits[k][i]);
          mout[k] = w;
          if (PAR) mperr[k] = ones[0];
          mval[k] = 1'b1;
          mcnt[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] ao[3], ac[3];
    logic        av[3], ab[3], ap[3];
    ao[0] = 32'(a_out); ao[1] = 32'(b_out); ao[2] = 32'(c_out);
    ac[0] = 32'(a_c);   ac[1] = 32'(b_c);   ac[2] = 32'(c_c);
    av[0] = a_v; av[1] = b_v; av[2] = c_v;
    ab[0] = a_b; ab[1] = b_b; ab[2] = c_b;
    ap[0] = a_p; ap[1] = b_p; ap[2] = c_p;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out[%0d]", k), ao[k], mout[k]);
      chk($sformatf("valid[%0d]", k), 32'(av[k]), 32'(mval[k]));
      chk($sformatf("busy[%0d]", k), 32'(ab[k]), 32'(mcnt[k] != 0));
      chk($sformatf("count[%0d]", k), ac[k], 32'(mcnt[k]));
      chk($sformatf("perr[%0d]", k), 32'(ap[k]), 32'(mperr[k]));
    end
  endtask

  task automatic step(input logic si, input logic en, input logic clr);
    @(negedge clk);
    serial_in = si; shift_en = en; clear = clr;
    @(posedge clk);
    #1;
    model_step(si, en, clr);
    check_all();
  endtask

  // Called right after step(): asserts reset between edges and checks that
  // outputs clear before any clock edge.
  task automatic pulse_reset();
    shift_en = 1'b0; clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #3 reset = 1'b0;
  endtask

  typedef struct {
    logic       si, en, clr;
    logic [3:0] eout;
    logic       ev;
    int         ecnt;
    logic       eperr;
    logic [3:0] erev;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic si, input logic en, input logic clr,
                              input logic [3:0] eout, input logic ev, input int ecnt,
                              input logic eperr, input logic [3:0] erev);
    vec_t v;
    v.si = si; v.en = en; v.clr = clr; v.eout = eout; v.ev = ev;
    v.ecnt = ecnt; v.eperr = eperr; v.erev = erev;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [9:0] bb_bits;
    int         bb_len;
    int         pulses[$];
    logic [7:0] hold8;
    logic [7:0] a5;

    model_reset();
    #1 check_all();
    #6 reset = 1'b0;

    // Table: 4-bit frames on dut_a (MSB first) and dut_b (LSB first).
    if (!PAR) begin
      add(1, 1, 0, 4'h0, 0, 1, 0, 4'h0);
      add(0, 1, 0, 4'h0, 0, 2, 0, 4'h0);
      add(1, 1, 0, 4'h0, 0, 3, 0, 4'h0);
      add(1, 1, 0, 4'hB, 1, 0, 0, 4'hD);
      add(0, 0, 0, 4'hB, 0, 0, 0, 4'hD);
      add(0, 1, 0, 4'hB, 0, 1, 0, 4'hD);
      add(1, 1, 0, 4'hB, 0, 2, 0, 4'hD);
      add(1, 1, 0, 4'hB, 0, 3, 0, 4'hD);
      add(0, 1, 0, 4'h6, 1, 0, 0, 4'h6);
    end else begin
      add(1, 1, 0, 4'h0, 0, 1, 0, 4'h0);
      add(0, 1, 0, 4'h0, 0, 2, 0, 4'h0);
      add(1, 1, 0, 4'h0, 0, 3, 0, 4'h0);
      add(1, 1, 0, 4'h0, 0, 4, 0, 4'h0);
      add(1, 1, 0, 4'hB, 1, 0, 0, 4'hD);
      add(0, 0, 0, 4'hB, 0, 0, 0, 4'hD);
      add(1, 1, 0, 4'hB, 0, 1, 0, 4'hD);
      add(0, 1, 0, 4'hB, 0, 2, 0, 4'hD);
      add(1, 1, 0, 4'hB, 0, 3, 0, 4'hD);
      add(1, 1, 0, 4'hB, 0, 4, 0, 4'hD);
      add(0, 1, 0, 4'hB, 1, 0, 1, 4'hD);
    end
    foreach (tbl[i]) begin
      step(tbl[i].si, tbl[i].en, tbl[i].clr);
      chk($sformatf("tbl%0d.out", i), 32'(a_out), 32'(tbl[i].eout));
      chk($sformatf("tbl%0d.valid", i), 32'(a_v), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.count", i), 32'(a_c), 32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d.perr", i), 32'(a_p), 32'(tbl[i].eperr));
      chk($sformatf("tbl%0d.rev", i), 32'(b_out), 32'(tbl[i].erev));
    end

    // Gaps and abort on the 8-bit instance.
    step(0, 0, 1);
    hold8 = c_out;
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("gap.count", 32'(c_c), 32'd3);
    step(1, 1, 1);
    chk("abort.count", 32'(c_c), 32'd0);
    chk("abort.busy", 32'(c_b), 32'd0);
    chk("abort.hold", 32'(c_out), 32'(hold8));
    chk("abort.valid", 32'(c_v), 32'd0);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) step(a5[i], 1, 0);
    if (PAR) step(1'b0, 1, 0);
    chk("a5.out", 32'(c_out), 32'hA5);
    chk("a5.valid", 32'(c_v), 32'd1);
    chk("a5.perr", 32'(c_p), 32'd0);

    // Async reset mid-frame, then a full frame.
    step(0, 0, 1);
    step(1, 1, 0); step(1, 1, 0);
    pulse_reset();
    chk("rst.out", 32'(a_out), 32'd0);
    chk("rst.count", 32'(a_c), 32'd0);
    step(0, 1, 0); step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
    if (PAR) step(0, 1, 0);
    chk("rst.frame", 32'(a_out), 32'h6);
    chk("rst.valid", 32'(a_v), 32'd1);

    // Back-to-back frames on dut_a with shift_en held high.
    step(0, 0, 1);
    if (!PAR) begin bb_bits = 10'b0000_1100_0011; bb_len = 8; end
    else      begin bb_bits = 10'b1100_0_0011_0 >> 0; bb_len = 10; end
    // Bits are consumed from the MSB end of the active length.
    for (int i = 0; i < bb_len; i++) begin
      step(bb_bits[bb_len-1-i], 1, 0);
      if (a_v) begin
        pulses.push_back(i);
        chk($sformatf("b2b.word%0d", pulses.size()), 32'(a_out),
            (pulses.size() == 1) ? 32'hC : 32'h3);
      end
    end
    chk("b2b.pulses", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2)
      chk("b2b.spacing", 32'(pulses[1] - pulses[0]), 32'(fl(0)));

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
